my_pc: RTL and testbench



---
 rtl/my_pc_pkg.sv | 17 +
 rtl/my_pc_stack.sv | 85 ++++++++
 rtl/my_pc.sv | 115 +++++++++++
 tb/tb_my_pc.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/my_pc_pkg.sv
// my_pc_pkg: shared types and default sizes for the my_pc program counter.
// The operation enum is the result of the priority decode of the control inputs.
package my_pc_pkg;

  localparam int PC_WIDTH = 16;
  localparam int PC_DEPTH = 8;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_INC  = 3'd1,
    OP_LD   = 3'd2,
    OP_RET  = 3'd3,
    OP_CALL = 3'd4,
    OP_CLR  = 3'd5
  } pc_op_t;

endpackage

// File: rtl/my_pc_stack.sv
// my_pc_stack: DEPTH x WIDTH return-address LIFO.
// depth/full/empty are registered; full/empty are updated from the next depth
// value so they line up with depth after every edge.
module my_pc_stack
  import my_pc_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int DEPTH = PC_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_val,
  output logic [WIDTH-1:0]         top,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      depth_r;
  logic [AW:0]      depth_nxt_s;
  logic             full_r;
  logic             empty_r;
  logic             do_push_s;
  logic             do_pop_s;
  logic [AW-1:0]    top_idx_s;

  // Qualify push/pop against occupancy and compute the next depth.
  always_comb begin
    do_push_s   = 1'b0;
    do_pop_s    = 1'b0;
    depth_nxt_s = depth_r;
    top_idx_s   = depth_r[AW-1:0] - AW'(1);
    if (clr) begin
      depth_nxt_s = '0;
    end else if (push && !full_r) begin
      do_push_s   = 1'b1;
      depth_nxt_s = depth_r + (AW+1)'(1);
    end else if (pop && !empty_r) begin
      do_pop_s    = 1'b1;
      depth_nxt_s = depth_r - (AW+1)'(1);
    end else begin
      depth_nxt_s = depth_r;
    end
  end

  // Occupancy and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_r <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      depth_r <= depth_nxt_s;
      full_r  <= (depth_nxt_s == (AW+1)'(DEPTH));
      empty_r <= (depth_nxt_s == (AW+1)'(0));
    end
  end

  // Storage array; a push writes the slot just above the current top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (do_push_s) begin
      mem_r[depth_r[AW-1:0]] <= push_val;
    end else begin
      mem_r <= mem_r;
    end
  end

  // do_pop_s only gates occupancy; the popped value is read through top.
  logic unused_pop_s;
  assign unused_pop_s = do_pop_s;

  assign top   = mem_r[top_idx_s];
  assign depth = depth_r;
  assign full  = full_r;
  assign empty = empty_r;

endmodule

// File: rtl/my_pc.sv
// my_pc: program counter with clear/load/increment and a return-address stack.
// Priority: clr > call > ret > ld > inc > hold. All outputs are registered.
// Optional feature macro MY_PC_ERR_EN adds a sticky err output that flags
// call while full and ret while empty.
module my_pc
  import my_pc_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int DEPTH = PC_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     ld,
  input  logic                     inc,
  input  logic                     call,
  input  logic                     ret,
  input  logic [WIDTH-1:0]         ld_val,
  output logic [WIDTH-1:0]         out,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     full,
  output logic                     empty
`ifdef MY_PC_ERR_EN
  ,
  output logic                     err
`endif
);

  pc_op_t           op_s;
  logic [WIDTH-1:0] out_r;
  logic [WIDTH-1:0] top_s;
  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             empty_s;

  // Priority decode of the control inputs into a single operation.
  always_comb begin
    op_s = OP_HOLD;
    if (clr) begin
      op_s = OP_CLR;
    end else if (call) begin
      op_s = OP_CALL;
    end else if (ret) begin
      op_s = OP_RET;
    end else if (ld) begin
      op_s = OP_LD;
    end else if (inc) begin
      op_s = OP_INC;
    end else begin
      op_s = OP_HOLD;
    end
  end

  // The stack drops pushes when full and ignores pops when empty.
  assign push_s = (op_s == OP_CALL);
  assign pop_s  = (op_s == OP_RET);

  my_pc_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .push     (push_s),
    .pop      (pop_s),
    .push_val (out_r + WIDTH'(1)),
    .top      (top_s),
    .depth    (depth),
    .full     (full_s),
    .empty    (empty_s)
  );

  // Address register update for the decoded operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r <= '0;
    end else begin
      case (op_s)
        OP_CLR:  out_r <= '0;
        OP_CALL: out_r <= ld_val;
        OP_RET:  out_r <= empty_s ? out_r : top_s;
        OP_LD:   out_r <= ld_val;
        OP_INC:  out_r <= out_r + WIDTH'(1);
        OP_HOLD: out_r <= out_r;
        default: out_r <= out_r;
      endcase
    end
  end

`ifdef MY_PC_ERR_EN
  logic err_r;

  // Sticky stack error, cleared only by reset or clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (op_s == OP_CLR) begin
      err_r <= 1'b0;
    end else if (((op_s == OP_CALL) && full_s) || ((op_s == OP_RET) && empty_s)) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;
`endif

  assign out   = out_r;
  assign full  = full_s;
  assign empty = empty_s;

endmodule

// File: tb/tb_my_pc.sv
// tb_my_pc: table-driven directed test of my_pc plus hand-written sequences
// for stack overflow/underflow and asynchronous reset.
`timescale 1ns/1ps
module tb_my_pc;

  localparam int W = 16;
  localparam int D = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr, ld, inc, call, ret;
  logic [W-1:0]  ld_val;
  logic [W-1:0]  out;
  logic [3:0]    depth;
  logic          full, empty;
`ifdef MY_PC_ERR_EN
  logic          err;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  my_pc #(.WIDTH(W), .DEPTH(D)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .ld     (ld),
    .inc    (inc),
    .call   (call),
    .ret    (ret),
    .ld_val (ld_val),
    .out    (out),
    .depth  (depth),
    .full   (full),
    .empty  (empty)
`ifdef MY_PC_ERR_EN
    ,
    .err    (err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         clr, call, ret, ld, inc;
    logic [W-1:0] ld_val;
    logic [W-1:0] exp_out;
    logic [3:0]   exp_depth;
    logic         exp_full, exp_empty, exp_err;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [W-1:0] e_out, input logic [3:0] e_depth,
                         input logic e_full, input logic e_empty, input logic e_err);
    chk({tag, ".out"},   32'(out),   32'(e_out));
    chk({tag, ".depth"}, 32'(depth), 32'(e_depth));
    chk({tag, ".full"},  32'(full),  32'(e_full));
    chk({tag, ".empty"}, 32'(empty), 32'(e_empty));
`ifdef MY_PC_ERR_EN
    chk({tag, ".err"},   32'(err),   32'(e_err));
`else
    if (e_err === 1'bx) $display("unexpected unknown err column in %s", tag);
`endif
  endtask

  task automatic drive(input logic c_clr, input logic c_call, input logic c_ret,
                       input logic c_ld, input logic c_inc, input logic [W-1:0] v);
    clr = c_clr; call = c_call; ret = c_ret; ld = c_ld; inc = c_inc; ld_val = v;
    @(posedge clk);
    #1;
    clr = 1'b0; call = 1'b0; ret = 1'b0; ld = 1'b0; inc = 1'b0;
  endtask

  function automatic vec_t mk(input logic c_clr, input logic c_call, input logic c_ret,
                              input logic c_ld, input logic c_inc, input logic [W-1:0] v,
                              input logic [W-1:0] e_out, input logic [3:0] e_depth,
                              input logic e_full, input logic e_empty, input logic e_err);
    vec_t r;
    r.clr = c_clr; r.call = c_call; r.ret = c_ret; r.ld = c_ld; r.inc = c_inc;
    r.ld_val = v; r.exp_out = e_out; r.exp_depth = e_depth;
    r.exp_full = e_full; r.exp_empty = e_empty; r.exp_err = e_err;
    return r;
  endfunction

  initial begin
    //            clr call ret ld inc  ld_val     out       dep  full empty err
    vecs[0]  = mk(0,  0,   0,  0, 1,   16'h0000,  16'h0001, 4'd0, 0, 1, 0);
    vecs[1]  = mk(0,  0,   0,  0, 1,   16'h0000,  16'h0002, 4'd0, 0, 1, 0);
    vecs[2]  = mk(0,  0,   0,  0, 1,   16'h0000,  16'h0003, 4'd0, 0, 1, 0);
    vecs[3]  = mk(0,  0,   0,  1, 0,   16'hFFFF,  16'hFFFF, 4'd0, 0, 1, 0);
    vecs[4]  = mk(0,  0,   0,  0, 1,   16'h0000,  16'h0000, 4'd0, 0, 1, 0);
    vecs[5]  = mk(0,  0,   0,  1, 0,   16'h0010,  16'h0010, 4'd0, 0, 1, 0);
    vecs[6]  = mk(0,  1,   0,  0, 0,   16'h0100,  16'h0100, 4'd1, 0, 0, 0);
    vecs[7]  = mk(0,  0,   1,  0, 0,   16'h0000,  16'h0011, 4'd0, 0, 1, 0);
    vecs[8]  = mk(0,  0,   0,  1, 0,   16'h0005,  16'h0005, 4'd0, 0, 1, 0);
    vecs[9]  = mk(0,  0,   1,  0, 0,   16'h0000,  16'h0005, 4'd0, 0, 1, 1);
    vecs[10] = mk(1,  0,   0,  0, 0,   16'h0000,  16'h0000, 4'd0, 0, 1, 0);
    vecs[11] = mk(0,  0,   0,  1, 0,   16'h0010,  16'h0010, 4'd0, 0, 1, 0);
    vecs[12] = mk(0,  1,   0,  0, 0,   16'h0100,  16'h0100, 4'd1, 0, 0, 0);
    vecs[13] = mk(0,  1,   1,  0, 0,   16'h0200,  16'h0200, 4'd2, 0, 0, 0);
    vecs[14] = mk(1,  1,   0,  1, 1,   16'h1234,  16'h0000, 4'd0, 0, 1, 0);
    vecs[15] = mk(0,  0,   0,  1, 1,   16'h0042,  16'h0042, 4'd0, 0, 1, 0);
    vecs[16] = mk(0,  0,   1,  1, 0,   16'h0077,  16'h0042, 4'd0, 0, 1, 1);
    vecs[17] = mk(1,  0,   0,  0, 0,   16'h0000,  16'h0000, 4'd0, 0, 1, 0);

    clr = 1'b0; ld = 1'b0; inc = 1'b0; call = 1'b0; ret = 1'b0; ld_val = '0;
    rst_n = 1'b0;
    #12;
    chk_all("reset", 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].clr, vecs[i].call, vecs[i].ret, vecs[i].ld, vecs[i].inc, vecs[i].ld_val);
      chk_all($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_depth,
              vecs[i].exp_full, vecs[i].exp_empty, vecs[i].exp_err);
    end

    // Overflow: nine calls from out=0 to 10,20,...,90; the ninth push is dropped.
    for (int k = 1; k <= 9; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, W'(10 * k));
      chk_all($sformatf("call%0d", k), W'(10 * k), (k >= 8) ? 4'd8 : 4'(k),
              (k >= 8), 1'b0, (k == 9));
    end

    // Pops return 71,61,...,1 (pushed from 70,60,...,0); err stays set.
    for (int j = 1; j <= 8; j++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, W'(0));
      chk_all($sformatf("ret%0d", j), W'(10 * (8 - j) + 1), 4'(8 - j),
              1'b0, (j == 8), 1'b1);
    end

    // Underflow after drain holds the address.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, W'(0));
    chk_all("ret_empty", 16'h0001, 4'd0, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset in the middle of a cycle with a non-empty stack.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0300);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    chk_all("pre_rst", 16'h0301, 4'd1, 1'b0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    chk_all("post_rst_inc", 16'h0001, 4'd0, 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
